// File: rtl/fb_div_pkg.sv
// Shared types and helpers for the PLL feedback divider.
// Optional feature macro used by this slice: FB_DIV_DUTY50_EN
// (adds a falling-edge half-cycle extender for 50 % duty on odd ratios).
package fb_div_pkg;

    // Width the ratio type is declared at; the divider itself is parameterised.
    localparam int N_W_DEFAULT = 8;

    // Smallest ratio the divider can realise (one high, one low cycle).
    localparam int DIV_MIN = 2;

    typedef logic [N_W_DEFAULT-1:0] ratio_t;

    // Ratios below DIV_MIN cannot form a period with a high and a low phase,
    // so they are raised to DIV_MIN. Works on a 32-bit zero-extended value so
    // it serves any divider width up to 32 bits.
    function automatic logic [31:0] clamp_ratio(input logic [31:0] r);
        return (r < 32'(DIV_MIN)) ? 32'(DIV_MIN) : r;
    endfunction

endpackage

// File: rtl/fb_divider_if.sv
// Control/status bundle of the feedback divider: enable, ratio load
// handshake and the divided clock outputs.
interface fb_divider_if #(
    parameter int N_W = 8
);
    logic           en;
    logic [N_W-1:0] div_ratio;
    logic           div_load;
    logic           div_ack;
    logic           ckfb;
    logic           fb_tick;
    logic [N_W-1:0] ratio_active;

    // Loop controller side: requests ratios and enables the divider.
    modport master (
        output en,
        output div_ratio,
        output div_load,
        input  div_ack,
        input  ckfb,
        input  fb_tick,
        input  ratio_active
    );

    // Divider side.
    modport slave (
        input  en,
        input  div_ratio,
        input  div_load,
        output div_ack,
        output ckfb,
        output fb_tick,
        output ratio_active
    );
endinterface

// File: rtl/fb_div_duty.sv
// Half-cycle high-time extender for odd divide ratios. The registered
// feedback clock is retimed on the falling VCO edge and OR-ed back in, so
// the high phase grows by half a VCO cycle while the rising edge is
// untouched. Only built when FB_DIV_DUTY50_EN is defined.
module fb_div_duty (
    input  logic clk,
    input  logic reset,
    input  logic ckfb_r,
    input  logic odd,
    output logic ckfb_out
);

    logic ext;

    // Falling-edge copy of the high phase, gated off for even ratios.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            ext <= 1'b0;
        end else begin
            ext <= ckfb_r & odd;
        end
    end

    assign ckfb_out = ckfb_r | ext;

endmodule

// File: rtl/fb_divider.sv
// Programmable integer feedback divider for the PLL loop. Divides the VCO
// clock by ratio_active and produces ckfb (high for floor(N/2) cycles) plus
// a one-cycle fb_tick at each ckfb rise. New ratios arrive through a
// load/ack handshake and are only applied at a period boundary so the
// phase detector never sees a truncated or stretched feedback period.
// Optional feature macro: FB_DIV_DUTY50_EN (50 % duty for odd ratios).
module fb_divider
    import fb_div_pkg::*;
#(
    parameter int N_W         = 8,
    parameter int DIV_DEFAULT = 16
) (
    input  logic         clk,
    input  logic         reset,
    fb_divider_if.slave  bus
);

    localparam logic [N_W-1:0] DEF_RATIO = N_W'(DIV_DEFAULT);
    localparam logic [N_W-1:0] DEF_CNT   = N_W'(DIV_DEFAULT - 1);

    logic [N_W-1:0] cnt;
    logic [N_W-1:0] cnt_next;
    logic [N_W-1:0] ratio_q;
    logic [N_W-1:0] ratio_next;
    logic [N_W-1:0] pend_ratio;
    logic [N_W-1:0] pend_ratio_next;
    logic [N_W-1:0] load_ratio;
    logic [N_W-1:0] n_eff;
    logic [N_W-1:0] half;
    logic           pend_v;
    logic           pend_v_next;
    logic           ckfb_q;
    logic           ckfb_next;
    logic           tick_q;
    logic           tick_next;
    logic           ack_q;
    logic           ack_next;
    logic           last;
    logic           wrap;
    logic           apply;

    assign load_ratio = N_W'(clamp_ratio(32'(bus.div_ratio)));

    // Period bookkeeping: wrap detection, ratio application and the
    // registered waveform values for the coming cycle.
    always_comb begin
        last  = (cnt == ratio_q - 1'b1);
        // With the divider disabled every edge behaves as a period boundary,
        // so pending ratios land immediately and re-enable starts a period.
        wrap  = !bus.en || last;
        apply = wrap && pend_v;
        n_eff = apply ? pend_ratio : ratio_q;
        half  = n_eff >> 1;

        ratio_next = n_eff;
        ack_next   = apply;

        if (bus.en) begin
            cnt_next  = last ? '0 : cnt + 1'b1;
            ckfb_next = (cnt_next < half);
            tick_next = last;
        end else begin
            // Park on the last count so the first enabled edge is a wrap.
            cnt_next  = n_eff - 1'b1;
            ckfb_next = 1'b0;
            tick_next = 1'b0;
        end
    end

    // Pending ratio register: newest load wins; a load coinciding with a
    // wrap is held for the following boundary because apply uses the old
    // pend_v.
    always_comb begin
        pend_ratio_next = pend_ratio;
        pend_v_next     = pend_v && !apply;
        if (bus.div_load) begin
            pend_ratio_next = load_ratio;
            pend_v_next     = 1'b1;
        end
    end

    // State registers on the VCO rising edge; reset discards any pending ratio.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= DEF_CNT;
            ratio_q    <= DEF_RATIO;
            pend_ratio <= DEF_RATIO;
            pend_v     <= 1'b0;
            ckfb_q     <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            ratio_q    <= ratio_next;
            pend_ratio <= pend_ratio_next;
            pend_v     <= pend_v_next;
            ckfb_q     <= ckfb_next;
            tick_q     <= tick_next;
            ack_q      <= ack_next;
        end
    end

`ifdef FB_DIV_DUTY50_EN
    fb_div_duty u_duty (
        .clk      (clk),
        .reset    (reset),
        .ckfb_r   (ckfb_q),
        .odd      (ratio_q[0]),
        .ckfb_out (bus.ckfb)
    );
`else
    assign bus.ckfb = ckfb_q;
`endif

    assign bus.fb_tick      = tick_q;
    assign bus.div_ack      = ack_q;
    assign bus.ratio_active = ratio_q;

endmodule

// File: tb/tb_fb_divider.sv
// Scoreboard bench for fb_divider: stimulus pushes the expected per-cycle
// outputs from a period-level reference model; a monitor pops and compares
// one entry after every rising VCO edge.
module tb_fb_divider;
    import fb_div_pkg::*;

    typedef struct {
        bit ck;
        bit tick;
        bit ack;
        int ratio;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    fb_divider_if #(.N_W(8)) bus ();

    fb_divider #(.N_W(8), .DIV_DEFAULT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: whole periods are laid out as lists of positions.
    int   m_n = 16;
    bit   m_pv = 0;
    int   m_pr = 16;
    int   per_q[$];
    bit   prev_base = 0;
    bit   prev_odd = 0;

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_edge(input bit en, input bit load, input int ratio, input bit rst);
        exp_t e;
        bit   base;
        if (rst) begin
            m_n = 16; m_pv = 0; m_pr = 16;
            per_q.delete();
            prev_base = 0; prev_odd = 0;
            e.ck = 0; e.tick = 0; e.ack = 0; e.ratio = 16;
            exp_q.push_back(e);
            return;
        end
        e.ack = 0;
        if (en) begin
            if (per_q.size() == 0) begin
                if (m_pv) begin
                    m_n = m_pr; m_pv = 0; e.ack = 1;
                end
                for (int k = 0; k < m_n; k++) per_q.push_back(k);
            end
            base   = (per_q[0] < m_n / 2);
            e.tick = (per_q[0] == 0);
            void'(per_q.pop_front());
        end else begin
            per_q.delete();
            if (m_pv) begin
                m_n = m_pr; m_pv = 0; e.ack = 1;
            end
            base   = 0;
            e.tick = 0;
        end
`ifdef FB_DIV_DUTY50_EN
        e.ck = base | (prev_base & prev_odd);
`else
        e.ck = base;
`endif
        prev_base = base;
        prev_odd  = (m_n % 2) == 1;
        e.ratio = m_n;
        if (load) begin
            m_pr = (ratio < DIV_MIN) ? DIV_MIN : ratio;
            m_pv = 1;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input bit en, input bit load, input int ratio, input bit rst);
        ratio_t r;
        @(negedge clk);
        r = ratio_t'(ratio);
        reset        = rst;
        bus.en       = en;
        bus.div_load = load;
        bus.div_ratio = r;
        model_edge(en, load, ratio, rst);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0);
    endtask

    // Advance until the next edge is a period boundary.
    task automatic to_wrap();
        int guard = 0;
        while (per_q.size() != 0 && guard < 300) begin
            step(1, 0, 0, 0);
            guard++;
        end
        check("wrap_reached", int'(per_q.size() == 0), 1);
    endtask

    // Advance until the counter reads 3 (four positions of the period used).
    task automatic to_cnt3();
        int guard = 0;
        while (per_q.size() != m_n - 4 && guard < 300) begin
            step(1, 0, 0, 0);
            guard++;
        end
        check("cnt3_reached", int'(per_q.size() == m_n - 4), 1);
    endtask

    // Monitor: one expected entry per rising edge, sampled 1 ns after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("ckfb", int'(bus.ckfb), int'(e.ck));
                check("fb_tick", int'(bus.fb_tick), int'(e.tick));
                check("div_ack", int'(bus.div_ack), int'(e.ack));
                check("ratio_active", int'(bus.ratio_active), e.ratio);
            end
        end
    end

    initial begin
        bus.en = 0;
        bus.div_load = 0;
        bus.div_ratio = '0;

        // Reset default, then enable: N=16 waveform.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        run(40);

        // Ratio change mid-period.
        step(1, 1, 10, 0);
        run(30);

        // Back to 16, then a load exactly on a wrap edge.
        step(1, 1, 16, 0);
        run(25);
        to_wrap();
        step(1, 1, 12, 0);
        run(40);

        // Two loads inside one period: only the second is applied.
        step(1, 1, 6, 0);
        run(2);
        step(1, 1, 9, 0);
        run(40);

        // Clamp of 0 and 1.
        step(1, 1, 0, 0);
        run(20);
        step(1, 1, 1, 0);
        run(20);

        // Odd ratio.
        step(1, 1, 7, 0);
        run(30);

        // Enable dropped at cnt = 3, then re-enabled.
        step(1, 1, 16, 0);
        run(20);
        to_cnt3();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        run(20);

        // Load while disabled applies on the next edge.
        step(0, 1, 5, 0);
        step(0, 0, 0, 0);
        run(15);

        // Reset pulse with a ratio pending.
        step(1, 1, 20, 0);
        run(2);
        step(1, 0, 0, 1);
        run(40);

        // Randomised operation.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 15) != 0,
                 $urandom_range(0, 19) == 0,
                 int'($urandom_range(0, 40)),
                 $urandom_range(0, 299) == 0);
        end

        @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fb_divider.md
# fb_divider

Programmable integer feedback divider closing the PLL loop: divides the VCO clock by N and produces the feedback clock `ckfb` consumed by the phase-frequency detector's feedback input. Ratio changes are taken through a load/acknowledge handshake and applied only at a period boundary, so the detector never sees a truncated or stretched feedback period. This block is synthesizable digital RTL and clocks directly off the VCO output.

## Interface
- `N_W`, default 8: ratio and counter width.
- `DIV_DEFAULT`, default 16: ratio active out of reset; must be ≥ 2.
- `clk  in  1`: VCO clock; all logic on its rising edge except the optional duty extender.
- `reset  in  1`: reset, asynchronous, active-high.
- `en  in  1`: divider enable.
- `div_ratio  in  N_W`: requested ratio N; sampled when `div_load` = 1.
- `div_load  in  1`: single-cycle request strobe.
- `div_ack  out  1`: one-cycle pulse on the edge where the pending ratio becomes active.
- `ckfb  out  1`: divided feedback clock.
- `fb_tick  out  1`: one-cycle pulse coincident with each `ckfb` rising edge.
- `ratio_active  out  N_W`: ratio currently in use.

## Operation
- Clamp: any `div_ratio` < 2 is stored as 2. Values 0 and 1 both become 2.
- Pending register:
  - `div_load` = 1 captures the clamped ratio and sets `pend_v`.
  - A later load before application overwrites the pending ratio. Only the latest value is applied, with one `div_ack`.
- Counter `cnt`, range 0..N-1.
  - When `en` = 1: the wrap edge is the edge where `cnt` = N-1. At that edge `cnt` goes to 0; otherwise `cnt` increments.
- Ratio application happens only on a wrap edge with `pend_v` = 1:
  - `ratio_active` takes the pending value.
  - `pend_v` is cleared.
  - `div_ack` = 1.
  - The period starting at that edge uses the new N.
- High length H = floor(N/2) clk cycles. `ckfb` is registered: `ckfb` <= (cnt_next < H).
- `fb_tick` is registered high on every wrap edge.
- `en` = 0:
  - Forces `cnt` = `ratio_active`-1 and `ckfb` = 0 at the next edge.
  - Pending ratios are applied on that edge as if it were a wrap.
  - `fb_tick` stays 0.
  - The first edge with `en` = 1 is a wrap edge.

## Timing
- Reset values:
  - `cnt` = `DIV_DEFAULT`-1
  - `ratio_active` = `DIV_DEFAULT`
  - `ckfb` = 0, `fb_tick` = 0, `div_ack` = 0
  - `pend_v` = 0
- First `ckfb` rise: on the first rising edge where `en` is sampled 1. Latency 1 edge.
- Steady state: rising edges of `ckfb` are exactly N clk cycles apart. High for H cycles, low for N-H cycles.
- Load and wrap on the same edge: the value goes to pending and is applied at the next wrap, not at this one. Its `div_ack` follows one full old-N period later.
- Load with `en` = 0: the value is applied on the next edge, with `div_ack` on that edge.
- N = 2: H = 1, so `ckfb` toggles every cycle.
- Reset asserted mid-period: all state returns to reset values immediately and any pending ratio is discarded.

## Configuration
- `FB_DIV_DUTY50_EN`
  - When defined, odd N produce a 50 % duty `ckfb`. The registered high phase (H = (N-1)/2) is OR-ed with a copy retimed on the falling edge of `clk`, which extends the high time by half a cycle.
  - For even N the extension is disabled.
  - Rising-edge timing of `ckfb` and `fb_tick` is unchanged.
- When undefined: no falling-edge logic; duty is floor(N/2)/N.

## Structure
- Package `fb_div_pkg`:
  - `ratio_t` (logic [N_W-1:0] at default width)
  - `DIV_MIN` = 2
  - function `clamp_ratio`
- Sub-module `fb_div_duty` contains the falling-edge half-cycle extender. It is instantiated only under `FB_DIV_DUTY50_EN`.
- The counter, pending register and handshake stay in `fb_divider`.

## Test plan
- **Reset default:** reset, then `en` = 1. `ckfb` rises on the first edge; rises repeat every 16 cycles; high 8 cycles; `fb_tick` is 1 on each rise.
- **Ratio change:** at N = 16, load 10 mid-period.
  - `div_ack` fires at the next wrap.
  - The next period is 10 cycles with high time 5.
  - `ratio_active` reads 10 from that edge.
- **Load on wrap edge and overwrite:**
  - Load 12 on a wrap edge: it applies one 16-cycle period later.
  - Load 6 then 9 within one period: only 9 is applied, with a single `div_ack`.
- **Clamp:** load 0, then 1. `ratio_active` = 2 and `ckfb` toggles every cycle.
- **Odd ratio:**
  - N = 7 without the macro: high 3 cycles, low 4 cycles.
  - N = 7 with `FB_DIV_DUTY50_EN`: high 3.5 cycles. Rise edges still 7 cycles apart.
- **Mid-operation disturbances:**
  - `en` dropped at `cnt` = 3: `ckfb` is 0 at the next edge; on re-enable `ckfb` rises on the first edge.
  - Reset pulsed with a pending ratio: `ratio_active` returns to 16 and no `div_ack` is produced.
